// File: rtl/multiplier_rr_if.sv
// Handshake bundles for multiplier_rr: a multi-flux FIFO read side and a write side.
// read_interface : one shared dout word, per-flux empty flags and per-flux read strobes.
// write_interface: one din word, per-flux full flags and a single write strobe.
// Modports: actor/master = multiplier side, slave = FIFO side.

interface read_interface #(
    parameter int DW = 8,
    parameter int N  = 2
);
    logic [DW-1:0] dout;
    logic [N-1:0]  empty;
    logic [N-1:0]  read;

    modport actor  (input dout, input empty, output read);
    modport master (input dout, input empty, output read);
    modport slave  (output dout, output empty, input read);
endinterface

interface write_interface #(
    parameter int DW = 8,
    parameter int N  = 2
);
    logic [DW-1:0] din;
    logic [N-1:0]  full;
    logic          write;

    modport actor  (output din, input full, output write);
    modport master (output din, input full, output write);
    modport slave  (input din, output full, input write);
endinterface

// File: rtl/multiplier_rr.sv
// Round-robin multi-flux multiplier: each flux loads a coefficient and block size, then
//   multiplies (max+1)^2 samples by it. Zero latency: reads and the product write share a cycle.
// Backpressure: a flux whose product FIFO is full is not served; its counters and reads hold.
// Ports: clk, rst (sync, active-high); read_port_opA/opB/ext_size (read_interface.actor);
//   write_port_prod (write_interface.actor). Every word is {tag, data}, data in the LSBs.
// Option: define MULTIPLIER_RR_SAT_EN to saturate the rounded product instead of wrapping.

module multiplier_rr #(
    parameter int FLUX   = 2,
    parameter int A_W    = 8,
    parameter int B_W    = 9,
    parameter int SIZE_W = 7,
    parameter int OUT_W  = 18,
    parameter int SHIFT  = 0
) (
    input  logic          clk,
    input  logic          rst,
    read_interface.actor  read_port_opA,
    read_interface.actor  read_port_opB,
    read_interface.actor  read_port_ext_size,
    write_interface.actor write_port_prod
);
    localparam int TAG_W = (FLUX > 1) ? $clog2(FLUX) : 1;
    localparam int RW    = A_W + B_W + 1;
    // Working width leaves headroom for the rounding add and for sign extension to OUT_W.
    localparam int WW    = ((RW > OUT_W) ? RW : OUT_W) + 1;
    localparam logic signed [WW-1:0] RND_C =
        (SHIFT > 0) ? (WW'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : {WW{1'b0}};

    typedef enum logic {IDLE = 1'b0, WORK = 1'b1} state_t;

    state_t                   state_q [FLUX];
    state_t                   state_d [FLUX];
    logic signed [B_W-1:0]    coeff_q [FLUX];
    logic signed [B_W-1:0]    coeff_d [FLUX];
    logic [SIZE_W-1:0]        max_q   [FLUX];
    logic [SIZE_W-1:0]        max_d   [FLUX];
    logic [SIZE_W-1:0]        cnt_h_q [FLUX];
    logic [SIZE_W-1:0]        cnt_h_d [FLUX];
    logic [SIZE_W-1:0]        cnt_v_q [FLUX];
    logic [SIZE_W-1:0]        cnt_v_d [FLUX];
    logic [TAG_W-1:0]         rr_q;
    logic [TAG_W-1:0]         rr_d;

    logic [FLUX-1:0]          elig;
    logic                     served;
    logic                     is_work;
    logic [TAG_W-1:0]         tag;
    logic [FLUX-1:0]          tag_oh;

    logic signed [A_W-1:0]    a_s;
    logic signed [WW-1:0]     prod_w;
    logic signed [WW-1:0]     shr_w;
    logic signed [OUT_W-1:0]  res;

    // Arbiter: first eligible flux searching upward from rr_q, wrapping modulo FLUX.
    always_comb begin : arbiter
        int idx;
        idx    = 0;
        served = 1'b0;
        tag    = '0;
        for (int f = 0; f < FLUX; f++) begin
            elig[f] = (state_q[f] == IDLE)
                    ? (!read_port_opB.empty[f] && !read_port_ext_size.empty[f])
                    : (!read_port_opA.empty[f] && !write_port_prod.full[f]);
        end
        for (int k = 0; k < FLUX; k++) begin
            idx = (int'(rr_q) + k) % FLUX;
            if (!served && elig[idx]) begin
                served = 1'b1;
                tag    = TAG_W'(idx);
            end
        end
        tag_oh  = served ? (FLUX'(1) << tag) : '0;
        is_work = served && (state_q[tag] == WORK);
    end

    // Product, round-half-up, arithmetic shift, then wrap or saturate to OUT_W.
    always_comb begin : datapath
        a_s    = read_port_opA.dout[A_W-1:0];
        prod_w = WW'(a_s) * WW'(coeff_q[tag]);
        shr_w  = (prod_w + RND_C) >>> SHIFT;
`ifdef MULTIPLIER_RR_SAT_EN
        if (shr_w > ((WW'(1) <<< (OUT_W - 1)) - WW'(1))) begin
            res = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (shr_w < -(WW'(1) <<< (OUT_W - 1))) begin
            res = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            res = shr_w[OUT_W-1:0];
        end
`else
        res = shr_w[OUT_W-1:0];
`endif
    end

    always_comb begin : next_state
        for (int f = 0; f < FLUX; f++) begin
            state_d[f] = state_q[f];
            coeff_d[f] = coeff_q[f];
            max_d[f]   = max_q[f];
            cnt_h_d[f] = cnt_h_q[f];
            cnt_v_d[f] = cnt_v_q[f];
        end
        rr_d = rr_q;
        if (served) begin
            rr_d = (int'(tag) == FLUX - 1) ? '0 : tag + 1'b1;
            if (state_q[tag] == IDLE) begin
                coeff_d[tag] = read_port_opB.dout[B_W-1:0];
                max_d[tag]   = read_port_ext_size.dout[SIZE_W-1:0];
                cnt_h_d[tag] = '0;
                cnt_v_d[tag] = '0;
                state_d[tag] = WORK;
            end else if (cnt_h_q[tag] != max_q[tag]) begin
                cnt_h_d[tag] = cnt_h_q[tag] + 1'b1;
            end else if (cnt_v_q[tag] != max_q[tag]) begin
                cnt_h_d[tag] = '0;
                cnt_v_d[tag] = cnt_v_q[tag] + 1'b1;
            end else begin
                // Last product of the block: back to IDLE for the next coefficient/size pair.
                cnt_h_d[tag] = '0;
                cnt_v_d[tag] = '0;
                state_d[tag] = IDLE;
            end
        end
    end

    // Strobes are forced low during reset so no FIFO word is consumed or produced.
    always_comb begin : strobes
        read_port_opB.read      = (served && !is_work && !rst) ? tag_oh : '0;
        read_port_ext_size.read = (served && !is_work && !rst) ? tag_oh : '0;
        read_port_opA.read      = (is_work && !rst) ? tag_oh : '0;
        write_port_prod.write   = is_work && !rst;
        write_port_prod.din     = {tag, res};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
            for (int f = 0; f < FLUX; f++) begin
                state_q[f] <= IDLE;
                coeff_q[f] <= '0;
                max_q[f]   <= '0;
                cnt_h_q[f] <= '0;
                cnt_v_q[f] <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int f = 0; f < FLUX; f++) begin
                state_q[f] <= state_d[f];
                coeff_q[f] <= coeff_d[f];
                max_q[f]   <= max_d[f];
                cnt_h_q[f] <= cnt_h_d[f];
                cnt_v_q[f] <= cnt_v_d[f];
            end
        end
    end

endmodule

// File: tb/tb_multiplier_rr.sv
// Scoreboard bench for multiplier_rr: modelled multi-flux FIFOs feed the DUT, expected
// products are queued per flux when a block is issued, and a negedge monitor checks strobes,
// arbitration order and every product word.

module tb_multiplier_rr;
    localparam int FLUX   = 3;
    localparam int A_W    = 8;
    localparam int B_W    = 9;
    localparam int SIZE_W = 3;
    localparam int OUT_W  = 12;
    localparam int SHIFT  = 2;
    localparam int TAG_W  = (FLUX > 1) ? $clog2(FLUX) : 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    read_interface  #(.DW(TAG_W + A_W),    .N(FLUX)) rd_a ();
    read_interface  #(.DW(TAG_W + B_W),    .N(FLUX)) rd_b ();
    read_interface  #(.DW(TAG_W + SIZE_W), .N(FLUX)) rd_e ();
    write_interface #(.DW(TAG_W + OUT_W),  .N(FLUX)) wr_p ();

    multiplier_rr #(
        .FLUX(FLUX), .A_W(A_W), .B_W(B_W), .SIZE_W(SIZE_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .read_port_opA      (rd_a),
        .read_port_opB      (rd_b),
        .read_port_ext_size (rd_e),
        .write_port_prod    (wr_p)
    );

    // FIFO contents (q*) and words staged by stimulus, moved in by the driver (p*).
    logic [TAG_W+A_W-1:0]    qa [FLUX][$];
    logic [TAG_W+A_W-1:0]    pa [FLUX][$];
    logic [TAG_W+B_W-1:0]    qb [FLUX][$];
    logic [TAG_W+B_W-1:0]    pb [FLUX][$];
    logic [TAG_W+SIZE_W-1:0] qx [FLUX][$];
    logic [TAG_W+SIZE_W-1:0] px [FLUX][$];
    int                      exp_q [FLUX][$];

    logic [TAG_W+A_W-1:0]    a_head [FLUX];
    logic [TAG_W+B_W-1:0]    b_head [FLUX];
    logic [TAG_W+SIZE_W-1:0] x_head [FLUX];
    logic [TAG_W+A_W-1:0]    a_dout;
    logic [TAG_W+B_W-1:0]    b_dout;
    logic [TAG_W+SIZE_W-1:0] x_dout;
    logic [FLUX-1:0] a_empty = '1, b_empty = '1, x_empty = '1, p_full = '0;
    logic [FLUX-1:0] full_force = '0;
    bit              full_rand = 1'b0;
    logic [FLUX-1:0] pop_a = '0, pop_b = '0, pop_x = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  [FLUX];
    int rem   [FLUX];   // products still owed by the open block of each flux; 0 = idle
    int rrp   = 0;

    assign rd_a.dout  = a_dout;
    assign rd_b.dout  = b_dout;
    assign rd_e.dout  = x_dout;
    assign rd_a.empty = a_empty;
    assign rd_b.empty = b_empty;
    assign rd_e.empty = x_empty;
    assign wr_p.full  = p_full;

    // The FIFO presents the head of whichever flux is being read.
    always_comb begin
        a_dout = '0;
        b_dout = '0;
        x_dout = '0;
        for (int f = 0; f < FLUX; f++) begin
            if (rd_a.read[f]) a_dout = a_head[f];
            if (rd_b.read[f]) b_dout = b_head[f];
            if (rd_e.read[f]) x_dout = x_head[f];
        end
    end

    function automatic int model(input int a, input int c);
        longint p;
        p = longint'(a) * longint'(c);
        if (SHIFT > 0) p = (p + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
`ifdef MULTIPLIER_RR_SAT_EN
        if (p > (longint'(1) <<< (OUT_W - 1)) - 1) p = (longint'(1) <<< (OUT_W - 1)) - 1;
        else if (p < -(longint'(1) <<< (OUT_W - 1))) p = -(longint'(1) <<< (OUT_W - 1));
`else
        p = p & ((longint'(1) <<< OUT_W) - 1);
        if (p >= (longint'(1) <<< (OUT_W - 1))) p = p - (longint'(1) <<< OUT_W);
`endif
        return int'(p);
    endfunction

    // Driver: just after each rising edge, apply the reads observed in the previous cycle,
    // admit staged words and pick this cycle's full flags.
    always @(posedge clk) begin
        #1;
        for (int f = 0; f < FLUX; f++) begin
            if (rst) begin
                qa[f].delete();
                qb[f].delete();
                qx[f].delete();
            end else begin
                if (pop_a[f] && qa[f].size() > 0) void'(qa[f].pop_front());
                if (pop_b[f] && qb[f].size() > 0) void'(qb[f].pop_front());
                if (pop_x[f] && qx[f].size() > 0) void'(qx[f].pop_front());
            end
            while (pa[f].size() > 0) qa[f].push_back(pa[f].pop_front());
            while (pb[f].size() > 0) qb[f].push_back(pb[f].pop_front());
            while (px[f].size() > 0) qx[f].push_back(px[f].pop_front());
            a_empty[f] = (qa[f].size() == 0);
            b_empty[f] = (qb[f].size() == 0);
            x_empty[f] = (qx[f].size() == 0);
            a_head[f]  = a_empty[f] ? '0 : qa[f][0];
            b_head[f]  = b_empty[f] ? '0 : qb[f][0];
            x_head[f]  = x_empty[f] ? '0 : qx[f][0];
        end
        pop_a  = '0;
        pop_b  = '0;
        pop_x  = '0;
        p_full = full_force | (full_rand ? FLUX'($urandom) : '0);
    end

    // Monitor: decide from FIFO status which flux must be served, check strobes and products.
    always @(negedge clk) begin
        logic [FLUX-1:0]   exp_rd_b, exp_rd_a;
        logic              exp_w;
        logic [SIZE_W-1:0] m;
        int  sel, f, got, gtag, e;
        bit  found, el;
        if (rst) begin
            n_cmp++;
            if (rd_a.read != 0 || rd_b.read != 0 || rd_e.read != 0 || wr_p.write != 0) begin
                n_bad++;
                $display("FAIL reset_strobes: opA=%b opB=%b ext=%b wr=%b, required all 0",
                         rd_a.read, rd_b.read, rd_e.read, wr_p.write);
            end
            for (int i = 0; i < FLUX; i++) rem[i] = 0;
            rrp = 0;
        end else begin
            found = 1'b0;
            sel   = 0;
            for (int k = 0; k < FLUX; k++) begin
                f  = (rrp + k) % FLUX;
                el = (rem[f] == 0) ? (!b_empty[f] && !x_empty[f]) : (!a_empty[f] && !p_full[f]);
                if (!found && el) begin
                    found = 1'b1;
                    sel   = f;
                end
            end
            exp_rd_b = (found && rem[sel] == 0) ? (FLUX'(1) << sel) : '0;
            exp_rd_a = (found && rem[sel] != 0) ? (FLUX'(1) << sel) : '0;
            exp_w    = found && rem[sel] != 0;
            n_cmp++;
            if (rd_b.read != exp_rd_b || rd_e.read != exp_rd_b || rd_a.read != exp_rd_a ||
                wr_p.write != exp_w) begin
                n_bad++;
                $display("FAIL strobes @%0t: opA=%b opB=%b ext=%b wr=%b, required opA=%b opB=%b ext=%b wr=%b",
                         $time, rd_a.read, rd_b.read, rd_e.read, wr_p.write,
                         exp_rd_a, exp_rd_b, exp_rd_b, exp_w);
            end
            if (wr_p.write) begin
                gtag = int'(wr_p.din[TAG_W+OUT_W-1:OUT_W]);
                got  = int'($signed(wr_p.din[OUT_W-1:0]));
                n_cmp++;
                if (gtag >= FLUX || exp_q[gtag].size() == 0) begin
                    n_bad++;
                    $display("FAIL product_extra: tag %0d value %0d, required no product", gtag, got);
                end else begin
                    e = exp_q[gtag].pop_front();
                    n_wr[gtag]++;
                    if (got != e || !(exp_w && gtag == sel)) begin
                        n_bad++;
                        $display("FAIL product: tag %0d value %0d, required tag %0d value %0d",
                                 gtag, got, sel, e);
                    end
                end
            end
            if (found) begin
                if (rem[sel] == 0) begin
                    m = x_head[sel][SIZE_W-1:0];
                    rem[sel] = (int'(m) + 1) * (int'(m) + 1);
                end else begin
                    rem[sel]--;
                end
                rrp = (sel + 1) % FLUX;
            end
            pop_a = rd_a.read;
            pop_b = rd_b.read;
            pop_x = rd_e.read;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Stage one block: coefficient, size and (m+1)^2 samples (sequential from base or random).
    task automatic add_block(input int f, input int c, input int m, input bit seq, input int base);
        logic [TAG_W+A_W-1:0] wa;
        int a;
        pb[f].push_back({TAG_W'($urandom), B_W'(c)});
        px[f].push_back({TAG_W'($urandom), SIZE_W'(m)});
        for (int i = 0; i < (m + 1) * (m + 1); i++) begin
            a  = seq ? base + i : int'($urandom_range(0, 255)) - 128;
            wa = {TAG_W'($urandom), A_W'(a)};
            pa[f].push_back(wa);
            exp_q[f].push_back(model(a, c));
        end
    endtask

    task automatic wait_drain(input int budget);
        int  t;
        int  left;
        bit  busy;
        t = 0;
        do begin
            tick(1);
            t++;
            busy = 1'b0;
            left = 0;
            for (int f = 0; f < FLUX; f++) begin
                left += exp_q[f].size();
                if (exp_q[f].size() > 0 || pa[f].size() > 0 || qa[f].size() > 0 ||
                    qb[f].size() > 0 || qx[f].size() > 0) busy = 1'b1;
            end
        end while (busy && t < budget);
        n_cmp++;
        if (busy) begin
            n_bad++;
            $display("FAIL drain: %0d products outstanding after %0d cycles, required 0", left, budget);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        int t;
        for (int f = 0; f < FLUX; f++) begin
            n_wr[f]   = 0;
            rem[f]    = 0;
            a_head[f] = '0;
            b_head[f] = '0;
            x_head[f] = '0;
        end
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(3);

        // coeff -3, ext 1: four products then idle, no fifth read
        add_block(0, -3, 1, 1'b1, 1);
        wait_drain(200);

        // rounding: 15 -> 4, -15 -> -4
        add_block(0, 5, 0, 1'b1, 3);
        add_block(0, 5, 0, 1'b1, -3);
        wait_drain(200);

        // extreme operands overflow OUT_W: saturate or wrap depending on build
        add_block(1, 255, 0, 1'b1, 127);
        add_block(1, -256, 0, 1'b1, -128);
        add_block(2, -256, 0, 1'b1, 127);
        add_block(2, 255, 0, 1'b1, -128);
        wait_drain(200);

        // all fluxes continuously eligible with single-product blocks
        for (int i = 0; i < 4; i++) begin
            for (int f = 0; f < FLUX; f++)
                add_block(f, int'($urandom_range(0, 511)) - 256, 0, 1'b0, 0);
        end
        wait_drain(300);

        // product FIFO of flux0 full for 3 cycles mid-block; flux1 keeps running
        add_block(0, 9, 2, 1'b0, 0);
        add_block(1, -7, 2, 1'b0, 0);
        tick(4);
        full_force = 3'b001;
        tick(3);
        full_force = '0;
        wait_drain(300);

        // reset after 2 products of a 4-product block, then a fresh block
        start = n_wr[1];
        add_block(1, 7, 1, 1'b0, 0);
        t = 0;
        while (n_wr[1] < start + 2 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        n_cmp++;
        if (n_wr[1] < start + 2) begin
            n_bad++;
            $display("FAIL pre_reset_products: %0d products, required 2", n_wr[1] - start);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int f = 0; f < FLUX; f++) begin
            pa[f].delete();
            pb[f].delete();
            px[f].delete();
            exp_q[f].delete();
        end
        tick(3);
        rst = 1'b0;
        start = n_wr[1];
        add_block(1, -5, 1, 1'b0, 0);
        wait_drain(200);
        n_cmp++;
        if (n_wr[1] - start != 4) begin
            n_bad++;
            $display("FAIL post_reset_block: %0d products, required 4", n_wr[1] - start);
        end

        // randomized traffic with random product backpressure
        full_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            add_block(int'($urandom_range(0, FLUX - 1)), int'($urandom_range(0, 511)) - 256,
                      int'($urandom_range(0, 3)), 1'b0, 0);
            tick(int'($urandom_range(0, 4)));
        end
        wait_drain(5000);
        full_rand = 1'b0;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
